// File: rtl/csr_pkg.sv
// Shared definitions for the CSR commit block: CSR addresses, mstatus bit positions,
// the commit FSM state type and the address decoder.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int NUM_CSR = 8;

    typedef enum logic [2:0] {
        IDX_MSTATUS, IDX_MIE, IDX_MTVEC, IDX_MSCRATCH,
        IDX_MEPC, IDX_MCAUSE, IDX_MTVAL, IDX_MIP
    } csr_idx_e;

    typedef enum logic [1:0] {IDLE, HOLD, TRAP, RET} state_e;

    typedef struct packed {
        logic     hit;
        csr_idx_e idx;
    } csr_sel_t;

    function automatic csr_sel_t csr_decode(input logic [11:0] addr);
        csr_sel_t sel;
        sel.hit = 1'b1;
        sel.idx = IDX_MSTATUS;
        case (addr)
            CSR_MSTATUS:  sel.idx = IDX_MSTATUS;
            CSR_MIE:      sel.idx = IDX_MIE;
            CSR_MTVEC:    sel.idx = IDX_MTVEC;
            CSR_MSCRATCH: sel.idx = IDX_MSCRATCH;
            CSR_MEPC:     sel.idx = IDX_MEPC;
            CSR_MCAUSE:   sel.idx = IDX_MCAUSE;
            CSR_MTVAL:    sel.idx = IDX_MTVAL;
            CSR_MIP:      sel.idx = IDX_MIP;
            default:      sel.hit = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/csr_pending_buf.sv
// One-entry holding register for a CSR write that arrived while the pipeline was stalled.
module csr_pending_buf #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            commit,
    input  logic [11:0]     wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            valid,
    output logic [11:0]     addr,
    output logic [XLEN-1:0] wdata
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= wr_addr;
            wdata <= wr_data;
        end else if (commit) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/csr_commit.sv
// Machine-mode CSR file with stall-deferred write commit, trap entry and mret.
// Optional macro CSR_VECTORED_EN enables vectored mtvec mode (mtvec[0] writable).
module csr_commit
    import csr_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wb_csr_we,
    input  logic [11:0]     wb_csr_addr,
    input  logic [XLEN-1:0] wb_csr_wdata,
    input  logic            stall_in,
    input  logic [11:0]     ex_csr_addr,
    output logic [XLEN-1:0] ex_csr_rdata,
    output logic            wb_temp_csr_we,
    output logic [11:0]     wb_temp_csr_addr,
    output logic [XLEN-1:0] wb_temp_csr_wdata,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_req,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    function automatic logic [XLEN-1:0] legalize(input csr_idx_e idx, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        if (idx == IDX_MEPC) r[0] = 1'b0;
        if (idx == IDX_MTVEC) begin
            r[1] = 1'b0;
`ifndef CSR_VECTORED_EN
            r[0] = 1'b0;
`endif
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] csr_q [NUM_CSR];
    logic [XLEN-1:0] csr_d [NUM_CSR];
    logic [XLEN-1:0] mtvec_rst;
    logic            buf_load, buf_commit, dir_we, do_trap, do_mret;
    csr_sel_t        ex_sel, wb_sel, buf_sel;

    csr_pending_buf #(.XLEN(XLEN)) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .load    (buf_load),
        .commit  (buf_commit),
        .wr_addr (wb_csr_addr),
        .wr_data (wb_csr_wdata),
        .valid   (wb_temp_csr_we),
        .addr    (wb_temp_csr_addr),
        .wdata   (wb_temp_csr_wdata)
    );

    assign mtvec_rst    = legalize(IDX_MTVEC, MTVEC_RST);
    assign ex_sel       = csr_decode(ex_csr_addr);
    assign wb_sel       = csr_decode(wb_csr_addr);
    assign buf_sel      = csr_decode(wb_temp_csr_addr);
    assign ex_csr_rdata = ex_sel.hit ? csr_q[ex_sel.idx] : '0;
    assign busy         = (state_q != IDLE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        buf_load   = 1'b0;
        buf_commit = 1'b0;
        dir_we     = 1'b0;
        do_trap    = 1'b0;
        do_mret    = 1'b0;
        case (state_q)
            HOLD: begin
                if (!stall_in || trap_req || mret_req) begin
                    buf_commit = 1'b1;
                    dir_we     = wb_csr_we && !stall_in;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                if (wb_csr_we) begin
                    // A trap/mret flushes the stall, so a stalled write retires directly.
                    if (!stall_in || trap_req || (mret_req && state_q == IDLE)) begin
                        dir_we = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
        endcase
        if (trap_req) begin
            do_trap = 1'b1;
            state_d = TRAP;
        end else if (mret_req && (state_q == IDLE || state_q == HOLD)) begin
            do_mret = 1'b1;
            state_d = RET;
        end
    end

    // Buffered write first, then the live write (it wins on a clash), then trap/mret fields.
    always_comb begin
        csr_d = csr_q;
        if (buf_commit && buf_sel.hit) csr_d[buf_sel.idx] = legalize(buf_sel.idx, wb_temp_csr_wdata);
        if (dir_we && wb_sel.hit)      csr_d[wb_sel.idx]  = legalize(wb_sel.idx, wb_csr_wdata);
        if (do_trap) begin
            csr_d[IDX_MEPC]   = legalize(IDX_MEPC, trap_pc);
            csr_d[IDX_MCAUSE] = trap_cause;
            csr_d[IDX_MTVAL]  = trap_val;
            csr_d[IDX_MSTATUS][MSTATUS_MPIE] = csr_d[IDX_MSTATUS][MSTATUS_MIE];
            csr_d[IDX_MSTATUS][MSTATUS_MIE]  = 1'b0;
            csr_d[IDX_MSTATUS][MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (do_mret) begin
            csr_d[IDX_MSTATUS][MSTATUS_MIE]  = csr_d[IDX_MSTATUS][MSTATUS_MPIE];
            csr_d[IDX_MSTATUS][MSTATUS_MPIE] = 1'b1;
        end
    end

    // NOTE: the CSR array is architectural state and must come out of reset defined, so it is reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            csr_q            <= '{default: '0};
            csr_q[IDX_MTVEC] <= mtvec_rst;
        end else begin
            state_q <= state_d;
            csr_q   <= csr_d;
        end
    end

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            TRAP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {csr_q[IDX_MTVEC][XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
                if (csr_q[IDX_MTVEC][0] && csr_q[IDX_MCAUSE][XLEN-1])
                    redirect_pc = {csr_q[IDX_MTVEC][XLEN-1:2], 2'b00}
                                + {{(XLEN-8){1'b0}}, csr_q[IDX_MCAUSE][5:0], 2'b00};
`endif
            end
            RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_q[IDX_MEPC];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_commit.sv
// Scoreboard bench for csr_commit: expected reads/redirects are queued as stimulus is driven.
module tb_csr_commit;
    import csr_pkg::*;

    localparam int XLEN = 64;

    logic            clk, rstn;
    logic            wb_csr_we, stall_in, trap_req, mret_req;
    logic [11:0]     wb_csr_addr, ex_csr_addr, wb_temp_csr_addr;
    logic [XLEN-1:0] wb_csr_wdata, ex_csr_rdata, wb_temp_csr_wdata;
    logic [XLEN-1:0] trap_cause, trap_pc, trap_val, redirect_pc;
    logic            wb_temp_csr_we, redirect_valid, busy;

    csr_commit #(.XLEN(XLEN), .MTVEC_RST(64'h0)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .wb_csr_we         (wb_csr_we),
        .wb_csr_addr       (wb_csr_addr),
        .wb_csr_wdata      (wb_csr_wdata),
        .stall_in          (stall_in),
        .ex_csr_addr       (ex_csr_addr),
        .ex_csr_rdata      (ex_csr_rdata),
        .wb_temp_csr_we    (wb_temp_csr_we),
        .wb_temp_csr_addr  (wb_temp_csr_addr),
        .wb_temp_csr_wdata (wb_temp_csr_wdata),
        .trap_req          (trap_req),
        .trap_cause        (trap_cause),
        .trap_pc           (trap_pc),
        .trap_val          (trap_val),
        .mret_req          (mret_req),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] addr;
        logic [63:0] val;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [63:0] redir_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input logic [11:0] a, input logic [63:0] v);
        rd_exp_t e;
        e.tag = tag; e.addr = a; e.val = v;
        rd_q.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            ex_csr_addr = e.addr;
            #1;
            check(e.tag, ex_csr_rdata, e.val);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        wb_csr_we = 1'b1; wb_csr_addr = a; wb_csr_wdata = d; stall_in = 1'b0;
        tick();
        wb_csr_we = 1'b0;
    endtask

    task automatic trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] val,
                        input logic [63:0] exp_redirect);
        trap_req = 1'b1; trap_cause = cause; trap_pc = pc; trap_val = val;
        redir_q.push_back(exp_redirect);
        tick();
        trap_req = 1'b0; mret_req = 1'b0;
    endtask

    // Bounded wait for the redirect pulse, then confirm it lasts one cycle.
    task automatic wait_redirect(input string tag);
        int          n;
        logic [63:0] exp;
        n = 0;
        while (!redirect_valid && n < 4) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(redirect_valid), 64'd1);
        exp = (redir_q.size() > 0) ? redir_q.pop_front() : 64'hDEAD;
        check({tag, "_pc"}, redirect_pc, exp);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        tick();
        check({tag, "_one_cycle"}, 64'(redirect_valid), 64'd0);
    endtask

    logic [63:0] exp_mtvec_107, exp_vec_pc;

    initial begin
`ifdef CSR_VECTORED_EN
        exp_mtvec_107 = 64'h105;
        exp_vec_pc    = 64'h11C;
`else
        exp_mtvec_107 = 64'h104;
        exp_vec_pc    = 64'h100;
`endif
        rstn = 1'b0; wb_csr_we = 1'b0; wb_csr_addr = '0; wb_csr_wdata = '0; stall_in = 1'b0;
        ex_csr_addr = '0; trap_req = 1'b0; mret_req = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_val = '0;
        #12;
        check("rst_temp_we", 64'(wb_temp_csr_we), 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        expect_rd("rst_mtvec", CSR_MTVEC, 64'h0);
        expect_rd("rst_mstatus", CSR_MSTATUS, 64'h0);
        drain();
        tick();
        rstn = 1'b1;
        tick();

        // Plain unstalled write
        wr(CSR_MSCRATCH, 64'hA5);
        expect_rd("mscratch_wr", CSR_MSCRATCH, 64'hA5);
        drain();
        check("mscratch_busy", 64'(busy), 64'd0);

        // Stalled write held for three cycles, invisible to EX until release
        wb_csr_we = 1'b1; wb_csr_addr = CSR_MTVEC; wb_csr_wdata = 64'h8000_0000; stall_in = 1'b1;
        tick();
        wb_csr_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_temp_we", 64'(wb_temp_csr_we), 64'd1);
            check("hold_temp_addr", 64'(wb_temp_csr_addr), 64'(CSR_MTVEC));
            check("hold_temp_wdata", wb_temp_csr_wdata, 64'h8000_0000);
            check("hold_busy", 64'(busy), 64'd1);
            expect_rd("hold_mtvec_hidden", CSR_MTVEC, 64'h0);
            drain();
            if (i < 2) tick();
        end
        stall_in = 1'b0;
        tick();
        check("release_temp_we", 64'(wb_temp_csr_we), 64'd0);
        expect_rd("release_mtvec", CSR_MTVEC, 64'h8000_0000);
        drain();

        // Trap entry then mret
        wr(CSR_MTVEC, 64'h100);
        wr(CSR_MSTATUS, 64'h8);
        trap(64'd2, 64'h2004, 64'h33, 64'h100);
        wait_redirect("trap1");
        expect_rd("trap1_mepc", CSR_MEPC, 64'h2004);
        expect_rd("trap1_mcause", CSR_MCAUSE, 64'd2);
        expect_rd("trap1_mtval", CSR_MTVAL, 64'h33);
        expect_rd("trap1_mstatus", CSR_MSTATUS, 64'h1880);
        drain();
        mret_req = 1'b1;
        redir_q.push_back(64'h2004);
        tick();
        mret_req = 1'b0;
        wait_redirect("mret1");
        expect_rd("mret1_mstatus", CSR_MSTATUS, 64'h1888);
        drain();

        // Held mepc write overridden by a trap; then a write during TRAP commits normally
        wb_csr_we = 1'b1; wb_csr_addr = CSR_MEPC; wb_csr_wdata = 64'h55; stall_in = 1'b1;
        tick();
        wb_csr_we = 1'b0;
        trap(64'd5, 64'h300, 64'h0, 64'h100);
        stall_in = 1'b0;
        check("trap_hold_temp_we", 64'(wb_temp_csr_we), 64'd0);
        wb_csr_we = 1'b1; wb_csr_addr = CSR_MSCRATCH; wb_csr_wdata = 64'h9;
        wait_redirect("trap2");
        wb_csr_we = 1'b0;
        expect_rd("trap2_mepc", CSR_MEPC, 64'h300);
        expect_rd("trap_state_write", CSR_MSCRATCH, 64'h9);
        drain();

        // Buffer commit and live write to the same address in one cycle
        wb_csr_we = 1'b1; wb_csr_addr = CSR_MSCRATCH; wb_csr_wdata = 64'h11; stall_in = 1'b1;
        tick();
        wb_csr_wdata = 64'h22; stall_in = 1'b0;
        tick();
        wb_csr_we = 1'b0;
        expect_rd("same_addr_live_wins", CSR_MSCRATCH, 64'h22);
        drain();

        // Field legalisation and unimplemented addresses
        wr(CSR_MEPC, 64'h1235);
        wr(CSR_MTVEC, 64'h107);
        wr(12'h123, 64'hFF);
        wr(CSR_MIP, 64'h880);
        expect_rd("mepc_bit0", CSR_MEPC, 64'h1234);
        expect_rd("mtvec_low_bits", CSR_MTVEC, exp_mtvec_107);
        expect_rd("unimpl_read", 12'h123, 64'h0);
        expect_rd("mip_rw", CSR_MIP, 64'h880);
        drain();

        // Vectored redirect (base only when the feature is off)
        wr(CSR_MTVEC, 64'h101);
        trap({1'b1, 63'd7}, 64'h4000, 64'h0, exp_vec_pc);
        wait_redirect("vec");

        // trap and mret together: trap wins
        mret_req = 1'b1;
        trap(64'd3, 64'h400, 64'h0, 64'h100);
        wait_redirect("trap_mret");
        expect_rd("trap_mret_mepc", CSR_MEPC, 64'h400);
        expect_rd("trap_mret_mcause", CSR_MCAUSE, 64'd3);
        drain();

        // Reset in the middle of HOLD discards the buffered write
        wb_csr_we = 1'b1; wb_csr_addr = CSR_MSCRATCH; wb_csr_wdata = 64'h77; stall_in = 1'b1;
        tick();
        wb_csr_we = 1'b0;
        check("prerst_temp_we", 64'(wb_temp_csr_we), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_temp_we", 64'(wb_temp_csr_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        expect_rd("midrst_mscratch", CSR_MSCRATCH, 64'h0);
        expect_rd("midrst_mtvec", CSR_MTVEC, 64'h0);
        drain();
        stall_in = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("postrst_temp_we", 64'(wb_temp_csr_we), 64'd0);
        expect_rd("postrst_mscratch", CSR_MSCRATCH, 64'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_commit.md
CSR_COMMIT -- requirements
Module: csr_commit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning CSR data width.
REQ-002 SHALL have parameter MTVEC_RST, default 64'h0, meaning mtvec reset value.
REQ-003 SHALL have ports: clk input 1 (sole clock); rstn input 1 (reset, asynchronous, active-low).
REQ-004 SHALL have: wb_csr_we input 1, wb_csr_addr input 12, wb_csr_wdata input XLEN (write-back-stage CSR write).
REQ-005 SHALL have: stall_in input 1 (pipeline stall; writes captured while high are deferred).
REQ-006 SHALL have: ex_csr_addr input 12, ex_csr_rdata output XLEN (committed read for EX).
REQ-007 SHALL have: wb_temp_csr_we output 1, wb_temp_csr_addr output 12, wb_temp_csr_wdata output XLEN (pending-write buffer, exported to forwarding).
REQ-008 SHALL have: trap_req input 1, trap_cause input XLEN, trap_pc input XLEN, trap_val input XLEN, mret_req input 1.
REQ-009 SHALL have: redirect_valid output 1, redirect_pc output XLEN, busy output 1.

Function
REQ-010 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344; other addresses read 0, writes dropped.
REQ-011 SHALL drive ex_csr_rdata combinationally from committed state only; pending buffer not visible.
REQ-012 SHALL use FSM states IDLE, HOLD, TRAP, RET.
REQ-013 IDLE: wb_csr_we & !stall_in -> commit at next edge; wb_csr_we & stall_in -> load buffer, go HOLD.
REQ-014 HOLD: wb_temp_csr_we=1; stall_in high -> hold buffer, ignore wb_csr_we; stall_in low -> commit buffer, return IDLE.
REQ-015 Same-cycle buffer commit and wb_csr_we to the same address: wb_csr_wdata wins.
REQ-016 trap_req (any state): commit pending buffer, then same edge mepc=trap_pc, mcause=trap_cause, mtval=trap_val, MPIE=MIE, MIE=0, MPP=2'b11; enter TRAP; trap fields override buffer on conflict.
REQ-017 TRAP: redirect_valid=1 for exactly one cycle, redirect_pc={mtvec[XLEN-1:2],2'b00}; return IDLE.
REQ-018 mret_req (IDLE/HOLD, no trap_req): commit buffer, MIE=MPIE, MPIE=1; enter RET; RET asserts redirect_valid one cycle with redirect_pc=mepc; return IDLE.
REQ-019 trap_req and mret_req together: trap wins, mret dropped.
REQ-020 busy SHALL be 1 in HOLD, TRAP, RET.
REQ-021 mepc writes SHALL clear bit 0; mtvec bit 1 forced 0.
REQ-022 wb_csr_we during TRAP/RET SHALL commit normally (IDLE rules) after trap updates, no conflict override.

Reset
REQ-023 rstn low SHALL asynchronously set state IDLE, all CSRs 0 except mtvec=MTVEC_RST, buffer cleared.
REQ-024 All outputs SHALL be 0 during reset except ex_csr_rdata (combinational from reset state).
REQ-025 Reset mid-HOLD SHALL discard the buffered write.

Configuration
REQ-026 Macro CSR_VECTORED_EN: defined -> mtvec[0]=1 and trap_cause[XLEN-1]=1 gives redirect_pc=base+4*trap_cause[5:0]; mtvec[0] writable.
REQ-027 Undefined: mtvec[0] reads 0, all traps redirect to base.

Structure
REQ-028 Shared package csr_pkg SHALL hold CSR address constants, mstatus bit indices, FSM state enum.
REQ-029 Sub-module csr_pending_buf (one-entry buffer: capture/hold/commit) is natural; the FSM stays in csr_commit.

Verification
REQ-030 Write 0x340<=0xA5 stall_in=0 -> next cycle ex read 0x340 = 0xA5, busy=0.
REQ-031 Write 0x305<=0x8000_0000 with stall_in=1 for 3 cycles -> wb_temp_csr_we=1, addr 0x305 for 3 cycles, read 0x305=0 until release, then 0x8000_0000.
REQ-032 mtvec=0x100, mstatus.MIE=1, trap_req cause=2 pc=0x2004 -> mepc=0x2004, mcause=2, MIE=0, MPIE=1, redirect_valid pulse with pc 0x100.
REQ-033 Following mret_req -> MIE=1, redirect pulse pc 0x2004.
REQ-034 HOLD (0x341<=0x55) + trap_req pc=0x300 same cycle -> mepc=0x300.
REQ-035 CSR_VECTORED_EN, mtvec=0x101, cause=2^63|7 -> redirect_pc=0x11C; rstn low mid-HOLD -> wb_temp_csr_we=0, CSRs reset.
